// File: rtl/seq_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_pkg
// Description : Shared types and constants for the parametrised sequential
//               shift/add multiplier: FSM state encoding and the legal
//               operand-width range.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_mult_pkg;

  // Controller states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Legal operand widths.
  localparam int c_WIDTH_MIN = 4;
  localparam int c_WIDTH_MAX = 64;

endpackage : seq_mult_pkg
`default_nettype wire

// File: rtl/seq_mult_param_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_param_if
// Description : Start/busy handshake and result bus of the sequential
//               multiplier.
//               start  - request, accepted only while busy=0
//               tc     - 1: two's-complement operands, 0: unsigned
//               mlier  - multiplier operand   (WIDTH bits)
//               mcand  - multiplicand operand (WIDTH bits)
//               busy   - operation in flight
//               valid  - one-cycle pulse, prodt is new in that cycle
//               prodt  - product (2*WIDTH bits), held until the next valid
//               master : requester side, slave : multiplier side.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_mult_param_if #(
  parameter int WIDTH = 32
);

  logic                 start;
  logic                 tc;
  logic [WIDTH-1:0]     mlier;
  logic [WIDTH-1:0]     mcand;
  logic                 busy;
  logic                 valid;
  logic [2*WIDTH-1:0]   prodt;

  modport master (
    output start,
    output tc,
    output mlier,
    output mcand,
    input  busy,
    input  valid,
    input  prodt
  );

  modport slave (
    input  start,
    input  tc,
    input  mlier,
    input  mcand,
    output busy,
    output valid,
    output prodt
  );

endinterface : seq_mult_param_if
`default_nettype wire

// File: rtl/mult_abs.sv
`default_nettype none
// ============================================================================
// Module      : mult_abs
// Description : Combinational conditional magnitude. When tc=1 the input is
//               treated as two's complement and its magnitude is returned
//               together with its sign; when tc=0 the input passes through
//               unchanged and sign is 0.
//               value - WIDTH-bit operand
//               tc    - operand is signed
//               mag   - WIDTH-bit unsigned magnitude
//               sign  - operand was negative
// Revision    : 1.0 - initial release
// ============================================================================
module mult_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             tc,
  output logic [WIDTH-1:0] mag,
  output logic             sign
);

  assign sign = tc & value[WIDTH-1];

  // The most negative value negates to itself, whose unsigned reading is
  // exactly 2^(WIDTH-1), so no extra bit is needed.
  assign mag = sign ? (-value) : value;

endmodule : mult_abs
`default_nettype wire

// File: rtl/seq_mult_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_param
// Description : Parametrised fixed-latency shift/add multiplier. Operands and
//               signed/unsigned mode are captured on an accepted start; the
//               magnitudes are multiplied over WIDTH iterations and the sign
//               is applied in a final fix-up cycle. The product is held
//               between valid pulses.
//               clock   - rising-edge clock
//               reset_n - asynchronous active-low reset
//               bus     - handshake/result interface (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_param #(
  parameter int WIDTH = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  seq_mult_param_if.slave   bus
);

  import seq_mult_pkg::*;

  localparam int                CNT_W      = $clog2(WIDTH + 1);
  localparam int                c_PW       = 2 * WIDTH;
  localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(WIDTH - 1);

  generate
    if (WIDTH < c_WIDTH_MIN || WIDTH > c_WIDTH_MAX) begin : g_width_illegal
      $error("seq_mult_param: WIDTH out of legal range");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Operand magnitude and sign extraction
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_mag_lier;
  logic [WIDTH-1:0] w_mag_cand;
  logic             w_sign_lier;
  logic             w_sign_cand;

  mult_abs #(.WIDTH(WIDTH)) u_abs_lier (
    .value (bus.mlier),
    .tc    (bus.tc),
    .mag   (w_mag_lier),
    .sign  (w_sign_lier)
  );

  mult_abs #(.WIDTH(WIDTH)) u_abs_cand (
    .value (bus.mcand),
    .tc    (bus.tc),
    .mag   (w_mag_cand),
    .sign  (w_sign_cand)
  );

  // --------------------------------------------------------------------------
  // Controller
  // --------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [c_PW-1:0]  r_acc;
  logic [c_PW-1:0]  r_h;
  logic [WIDTH-1:0] r_q;
  logic             r_neg;
  logic             r_valid;
  logic [c_PW-1:0]  r_prodt;
  logic [c_PW-1:0]  w_fixed;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // The edge that takes the counter to WIDTH is the last iteration.
        if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = FIX;
        end
      end
      FIX: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Sign fix-up at full product width; negating zero stays zero.
  assign w_fixed = r_neg ? (-r_acc) : r_acc;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_h     <= '0;
      r_q     <= '0;
      r_neg   <= 1'b0;
      r_valid <= 1'b0;
      r_prodt <= '0;
    end else begin
      r_valid <= (r_state == FIX);
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_acc <= '0;
            r_h   <= {{WIDTH{1'b0}}, w_mag_cand};
            r_q   <= w_mag_lier;
            r_neg <= w_sign_lier ^ w_sign_cand;
            r_cnt <= '0;
          end
        end
        RUN: begin
          if (r_q[0]) begin
            r_acc <= r_acc + r_h;
          end
          r_h   <= r_h << 1;
          r_q   <= r_q >> 1;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          r_prodt <= w_fixed;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy  = (r_state != IDLE);
  assign bus.valid = r_valid;
  assign bus.prodt = r_prodt;

endmodule : seq_mult_param
`default_nettype wire

// File: tb/tb_seq_mult_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mult_param
// Description : Self-checking bench for seq_mult_param at WIDTH=32 and
//               WIDTH=8, with a reference product computed by wide
//               sign/zero-extended arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult_param;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  seq_mult_param_if #(.WIDTH(32)) b32 ();
  seq_mult_param_if #(.WIDTH(8))  b8 ();

  seq_mult_param #(.WIDTH(32)) u_dut32 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b32)
  );

  seq_mult_param #(.WIDTH(8)) u_dut8 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b8)
  );

  int checks = 0;
  int errors = 0;

  // Last product each DUT should be holding.
  logic [127:0] last32;
  logic [127:0] last8;

  // Reference: extend both operands to 128 bits, multiply, keep 2*w bits.
  function automatic logic [127:0] model(input int w, input bit tc,
                                         input logic [63:0] a,
                                         input logic [63:0] b);
    logic signed [127:0] x;
    logic signed [127:0] y;
    logic signed [127:0] p;
    logic [127:0] m;
    for (int i = 0; i < 128; i++) begin
      if (i < w) begin
        x[i] = a[i];
        y[i] = b[i];
      end else begin
        x[i] = tc & a[w-1];
        y[i] = tc & b[w-1];
      end
    end
    p = x * y;
    m = (128'd1 << (2 * w)) - 128'd1;
    return p & m;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Corner-biased operand.
  function automatic logic [63:0] pick(input int w);
    logic [63:0] v;
    logic [63:0] msb;
    msb = 64'd1 << (w - 1);
    case ($urandom_range(0, 4))
      0: v = msb;
      1: v = (msb << 1) - 64'd1;
      2: v = 64'($urandom_range(0, 1));
      3: v = msb - 64'd1;
      default: v = rnd64();
    endcase
    return v;
  endfunction

  task automatic drive(input bit w8, input bit s, input bit tc,
                       input logic [63:0] a, input logic [63:0] b);
    if (w8) begin
      b8.start = s;
      b8.tc    = tc;
      b8.mlier = a[7:0];
      b8.mcand = b[7:0];
    end else begin
      b32.start = s;
      b32.tc    = tc;
      b32.mlier = a[31:0];
      b32.mcand = b[31:0];
    end
  endtask

  // Runs one operation and reports what was observed. Sample index k counts
  // falling edges after the request was presented; the accepting rising edge
  // lies before k=1. Operands are scrambled once accepted.
  task automatic run_op(input bit w8, input bit pre, input bit tc,
                        input logic [63:0] a, input logic [63:0] b,
                        input bit stray, input bit chain, input bit ntc,
                        input logic [63:0] na, input logic [63:0] nb,
                        output int vpos, output int npulse, output int nbusy,
                        output logic [127:0] prod, output bit stable);
    int w;
    logic [127:0] last;
    logic [127:0] p;
    bit bsy;
    bit vld;
    w = w8 ? 8 : 32;
    last = w8 ? last8 : last32;
    vpos = 0;
    npulse = 0;
    nbusy = 0;
    prod = '0;
    stable = 1'b1;
    if (!pre) begin
      @(negedge clock);
      drive(w8, 1'b1, tc, a, b);
    end
    for (int k = 1; k <= w + 2; k++) begin
      @(negedge clock);
      bsy = w8 ? b8.busy : b32.busy;
      vld = w8 ? b8.valid : b32.valid;
      p   = w8 ? 128'(b8.prodt) : 128'(b32.prodt);
      if (bsy) nbusy++;
      if (vld) begin
        npulse++;
        if (vpos == 0) begin
          vpos = k;
          prod = p;
        end
      end
      if (k <= w + 1 && p !== last) stable = 1'b0;
      if (k == 1 || k == 5 || k == w + 2)
        drive(w8, 1'b0, 1'($urandom()), rnd64(), rnd64());
      if (stray && (k == 4 || k == w || k == w + 1))
        drive(w8, 1'b1, 1'($urandom()), rnd64(), rnd64());
      if (chain && k == w + 2)
        drive(w8, 1'b1, ntc, na, nb);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (b32.busy !== 1'b0 || b32.valid !== 1'b0 || b32.prodt !== 64'd0) begin
      errors++;
      $display("FAIL reset32: busy=%b valid=%b prodt=%h, need 0 0 0",
               b32.busy, b32.valid, b32.prodt);
    end
    checks++;
    if (b8.busy !== 1'b0 || b8.valid !== 1'b0 || b8.prodt !== 16'd0) begin
      errors++;
      $display("FAIL reset8: busy=%b valid=%b prodt=%h, need 0 0 0",
               b8.busy, b8.valid, b8.prodt);
    end
    reset_n = 1'b1;
    last32 = '0;
    last8 = '0;
    begin
      int nv;
      nv = 0;
      repeat (6) begin
        @(negedge clock);
        if (b32.valid || b8.valid || b32.busy || b8.busy) nv++;
      end
      checks++;
      if (nv !== 0) begin
        errors++;
        $display("FAIL idle_quiet: %0d active samples without start, need 0", nv);
      end
    end
  endtask

  task automatic test_unsigned_max();
    int vpos, npulse, nbusy;
    logic [127:0] prod;
    bit stable;
    run_op(1'b0, 1'b0, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 1'b0,
           1'b0, 64'd0, 64'd0, vpos, npulse, nbusy, prod, stable);
    checks++;
    if (prod !== 128'hFFFFFFFE00000001) begin
      errors++;
      $display("FAIL umax_prod: got %h need fffffffe00000001", prod);
    end
    checks++;
    if (vpos !== 34 || npulse !== 1) begin
      errors++;
      $display("FAIL umax_valid: pos=%0d pulses=%0d need 34 1", vpos, npulse);
    end
    checks++;
    if (nbusy !== 33) begin
      errors++;
      $display("FAIL umax_busy: busy cycles=%0d need 33", nbusy);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL umax_hold: prodt changed before valid (got 0, need 1)");
    end
    last32 = 128'hFFFFFFFE00000001;
  endtask

  task automatic test_signed_32();
    int vpos, npulse, nbusy;
    logic [127:0] prod;
    bit stable;
    run_op(1'b0, 1'b0, 1'b1, 64'hFFFFFFFD, 64'd7, 1'b0, 1'b0,
           1'b0, 64'd0, 64'd0, vpos, npulse, nbusy, prod, stable);
    checks++;
    if (prod !== 128'hFFFFFFFFFFFFFFEB || vpos !== 34 || !stable) begin
      errors++;
      $display("FAIL signed_m3x7: prod=%h pos=%0d hold=%0d need ffffffffffffffeb 34 1",
               prod, vpos, stable);
    end
    last32 = 128'hFFFFFFFFFFFFFFEB;
    run_op(1'b0, 1'b0, 1'b0, 64'hFFFFFFFD, 64'd7, 1'b0, 1'b0,
           1'b0, 64'd0, 64'd0, vpos, npulse, nbusy, prod, stable);
    checks++;
    if (prod !== 128'h00000006FFFFFFEB || vpos !== 34 || !stable) begin
      errors++;
      $display("FAIL unsigned_fffffffdx7: prod=%h pos=%0d hold=%0d need 00000006ffffffeb 34 1",
               prod, vpos, stable);
    end
    last32 = 128'h00000006FFFFFFEB;
  endtask

  task automatic test_width8();
    int vpos, npulse, nbusy;
    logic [127:0] prod;
    bit stable;
    run_op(1'b1, 1'b0, 1'b1, 64'h80, 64'h80, 1'b0, 1'b0,
           1'b0, 64'd0, 64'd0, vpos, npulse, nbusy, prod, stable);
    checks++;
    if (prod !== 128'h4000) begin
      errors++;
      $display("FAIL w8_80x80: got %h need 4000", prod);
    end
    checks++;
    if (vpos !== 10 || npulse !== 1 || nbusy !== 9) begin
      errors++;
      $display("FAIL w8_latency: pos=%0d pulses=%0d busy=%0d need 10 1 9",
               vpos, npulse, nbusy);
    end
    last8 = 128'h4000;
    run_op(1'b1, 1'b0, 1'b1, 64'h80, 64'h7F, 1'b0, 1'b0,
           1'b0, 64'd0, 64'd0, vpos, npulse, nbusy, prod, stable);
    checks++;
    if (prod !== 128'hC080 || !stable) begin
      errors++;
      $display("FAIL w8_80x7f: got %h hold=%0d need c080 1", prod, stable);
    end
    last8 = 128'hC080;
  endtask

  task automatic test_back_to_back();
    int vpos, npulse, nbusy;
    logic [127:0] prod;
    logic [127:0] exp1;
    logic [63:0] a;
    logic [63:0] b;
    bit stable;
    bit tc;
    a = rnd64();
    b = rnd64();
    tc = 1'($urandom());
    exp1 = model(32, tc, a, b);
    run_op(1'b0, 1'b0, tc, a, b, 1'b1, 1'b1, 1'b0, 64'd5, 64'd6,
           vpos, npulse, nbusy, prod, stable);
    checks++;
    if (prod !== exp1 || vpos !== 34 || npulse !== 1 || nbusy !== 33 || !stable) begin
      errors++;
      $display("FAIL b2b_first: prod=%h pos=%0d pulses=%0d busy=%0d hold=%0d need %h 34 1 33 1",
               prod, vpos, npulse, nbusy, stable, exp1);
    end
    last32 = exp1;
    run_op(1'b0, 1'b1, 1'b0, 64'd5, 64'd6, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0,
           vpos, npulse, nbusy, prod, stable);
    checks++;
    if (prod !== 128'd30 || vpos !== 34 || npulse !== 1 || nbusy !== 33 || !stable) begin
      errors++;
      $display("FAIL b2b_second: prod=%h pos=%0d pulses=%0d busy=%0d hold=%0d need 1e 34 1 33 1",
               prod, vpos, npulse, nbusy, stable);
    end
    last32 = 128'd30;
  endtask

  task automatic test_zero_neg();
    int vpos, npulse, nbusy;
    logic [127:0] prod;
    bit stable;
    run_op(1'b0, 1'b0, 1'b1, 64'd0, 64'h80000000, 1'b0, 1'b0,
           1'b0, 64'd0, 64'd0, vpos, npulse, nbusy, prod, stable);
    checks++;
    if (prod !== 128'd0 || vpos !== 34 || npulse !== 1) begin
      errors++;
      $display("FAIL zero32: prod=%h pos=%0d pulses=%0d need 0 34 1",
               prod, vpos, npulse);
    end
    last32 = '0;
    run_op(1'b1, 1'b0, 1'b1, 64'h80, 64'd0, 1'b0, 1'b0,
           1'b0, 64'd0, 64'd0, vpos, npulse, nbusy, prod, stable);
    checks++;
    if (prod !== 128'd0 || vpos !== 10 || npulse !== 1) begin
      errors++;
      $display("FAIL zero8: prod=%h pos=%0d pulses=%0d need 0 10 1",
               prod, vpos, npulse);
    end
    last8 = '0;
  endtask

  task automatic test_random();
    int vpos, npulse, nbusy;
    logic [127:0] prod;
    logic [127:0] exp;
    logic [63:0] a;
    logic [63:0] b;
    bit stable;
    bit tc;
    bit w8;
    int w;
    for (int n = 0; n < 40; n++) begin
      w8 = (n % 2) == 1;
      w = w8 ? 8 : 32;
      a = pick(w);
      b = pick(w);
      tc = 1'($urandom());
      exp = model(w, tc, a, b);
      run_op(w8, 1'b0, tc, a, b, 1'($urandom()), 1'b0, 1'b0, 64'd0, 64'd0,
             vpos, npulse, nbusy, prod, stable);
      checks++;
      if (prod !== exp || vpos !== w + 2 || npulse !== 1 ||
          nbusy !== w + 1 || !stable) begin
        errors++;
        $display("FAIL random w=%0d tc=%0d a=%h b=%h: prod=%h pos=%0d pulses=%0d busy=%0d hold=%0d need %h %0d 1 %0d 1",
                 w, tc, a, b, prod, vpos, npulse, nbusy, stable, exp, w + 2, w + 1);
      end
      if (w8) last8 = exp;
      else last32 = exp;
    end
  endtask

  task automatic test_reset_midrun();
    int vpos, npulse, nbusy;
    int nv;
    int nb;
    logic [127:0] prod;
    logic [127:0] exp;
    logic [63:0] a;
    logic [63:0] b;
    bit stable;
    @(negedge clock);
    drive(1'b0, 1'b1, 1'b0, rnd64(), rnd64());
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 1) drive(1'b0, 1'b0, 1'b0, rnd64(), rnd64());
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (b32.busy !== 1'b0 || b32.valid !== 1'b0 || b32.prodt !== 64'd0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b valid=%b prodt=%h, need 0 0 0",
               b32.busy, b32.valid, b32.prodt);
    end
    @(negedge clock);
    reset_n = 1'b1;
    last32 = '0;
    last8 = '0;
    nv = 0;
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (b32.valid) nv++;
      if (b32.busy) nb++;
    end
    checks++;
    if (nv !== 0 || nb !== 0) begin
      errors++;
      $display("FAIL midrun_after: valid=%0d busy=%0d samples, need 0 0", nv, nb);
    end
    a = rnd64();
    b = rnd64();
    exp = model(32, 1'b1, a, b);
    run_op(1'b0, 1'b0, 1'b1, a, b, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0,
           vpos, npulse, nbusy, prod, stable);
    checks++;
    if (prod !== exp || vpos !== 34 || npulse !== 1 || !stable) begin
      errors++;
      $display("FAIL midrun_fresh: prod=%h pos=%0d pulses=%0d hold=%0d need %h 34 1 1",
               prod, vpos, npulse, stable, exp);
    end
    last32 = exp;
  endtask

  initial begin
    reset_n = 1'b0;
    last32 = '0;
    last8 = '0;
    drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    test_reset();
    test_unsigned_max();
    test_signed_32();
    test_width8();
    test_back_to_back();
    test_zero_neg();
    test_random();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_mult_param
`default_nettype wire
